mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported unified memory between instruction fetch (IF) and the data-memory stage (DM).
//   Per-port req/done handshake, registered grant FSM, fixed DM priority with an IF anti-starvation limit,
//   and an ack timeout. Drives pipe_stall so the pipeline registers freeze while any access is outstanding.
// PARAMETERS
//   AW            32  address width (byte address)
//   DW            32  data width
//   MAX_DM_STREAK 4   consecutive DM grants allowed while IF waits; next grant then forced to IF (>=1)
//   TIMEOUT       15  BUSY cycles without mem_ack before abort (>=1); counter width = clog2(TIMEOUT+1)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   if_req     in   1   IF read request; held with if_addr stable until if_done
//   if_addr    in   AW  IF read address
//   if_rdata   out  DW  IF read data, valid while if_done=1
//   if_done    out  1   one-cycle completion pulse for IF
//   dm_req     in   1   DM request; held with dm_we/dm_addr/dm_wdata stable until dm_done
//   dm_we      in   1   1=write, 0=read
//   dm_addr    in   AW  DM address
//   dm_wdata   in   DW  DM write data
//   dm_rdata   out  DW  DM read data, valid while dm_done=1 (0 for writes)
//   dm_done    out  1   one-cycle completion pulse for DM
//   mem_req    out  1   memory access active
//   mem_we     out  1   memory write enable
//   mem_addr   out  AW  memory address
//   mem_wdata  out  DW  memory write data
//   mem_rdata  in   DW  memory read data, sampled when mem_ack=1
//   mem_ack    in   1   memory completion, single-cycle, only honoured while mem_req=1
//   pipe_stall out  1   (if_req & ~if_done) | (dm_req & ~dm_done), combinational
//   bus_err    out  1   sticky: set on any timeout, cleared only by rst
// BEHAVIOUR
//   Reset: state=IDLE; mem_req, mem_we, if_done, dm_done, bus_err = 0; mem_addr, mem_wdata, if_rdata,
//     dm_rdata = 0; streak and timeout counters = 0. Reset mid-access drops it silently; no done pulse.
//   States: IDLE, BUSY_IF, BUSY_DM. mem_req=1 exactly in the BUSY states.
//   IDLE: effective requests: ifv = if_req & ~if_done, dmv = dm_req & ~dm_done (a requester in its done
//     cycle is never re-granted). Grant order:
//     - dmv & ifv & streak==MAX_DM_STREAK -> BUSY_IF, streak<=0
//     - dmv -> BUSY_DM; streak<=streak+1 if ifv, else streak<=0 (saturate at MAX_DM_STREAK)
//     - ifv -> BUSY_IF, streak<=0
//     - none -> stay IDLE.
//     On grant: mem_addr/mem_we/mem_wdata latched from the granted port (mem_we=0 for IF); timeout cnt<=0.
//   BUSY_x:
//     - mem_ack=1 -> IDLE; x_rdata<=mem_rdata (0 if DM write); x_done<=1 for exactly the next cycle.
//     - no ack, cnt==TIMEOUT-1 -> IDLE; x_done<=1, x_rdata<=0, bus_err<=1.
//     - else cnt<=cnt+1; mem_* outputs held stable.
//     - ack and timeout in the same cycle: ack wins, no error.
//   Latency: req sampled in IDLE at edge N; mem_req high in cycle N+1; ack in cycle N+1+k gives done in
//     cycle N+2+k. Minimum request-to-done = 2 cycles after the sampling edge.
//   Back-to-back: in a done cycle state is IDLE, so the other port can be granted at that edge.
//   Port inputs are ignored in BUSY states; requester changes there are protocol violations
//     (assertion only, no recovery).
//   if_done and dm_done are never high together; mem_ack while IDLE is ignored.
// TESTING
//   1 Lone IF read @0x100, mem acks on first BUSY cycle with 0xA5A5A5A5 -> if_done 2 cycles after
//     req sampled, if_rdata=0xA5A5A5A5, pipe_stall high until the done cycle.
//   2 IF and DM requests in the same cycle, DM write 0x55 to 0x40 -> DM served first with mem_we=1,
//     mem_wdata=0x55; IF granted on the dm_done edge; dm_rdata=0.
//   3 dm_req re-issued every done cycle plus constant if_req, MAX_DM_STREAK=4 -> grant order
//     DM,DM,DM,DM,IF, then the pattern repeats.
//   4 mem_ack never asserted, TIMEOUT=15 -> done after 15 BUSY cycles, rdata=0, bus_err=1 and stays 1
//     through later good accesses.
//   5 rst pulsed mid BUSY_DM -> all outputs 0 asynchronously, no dm_done; fresh request completes normally.
//   6 mem_ack asserted on the cycle cnt==TIMEOUT-1 -> normal completion with the acked data, bus_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the data-memory stage (DM). DM has fixed priority, with a streak limit so a
// waiting IF is eventually served, and every access is aborted after TIMEOUT busy
// cycles without mem_ack (sticky bus_err).
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          pipe_stall,
    output logic          bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          bus_err_q, bus_err_d;

    // A requester sitting in its done cycle is not a fresh request.
    logic ifv, dmv, take_if, take_dm, streak_full;
    assign ifv         = if_req & ~if_done_q;
    assign dmv         = dm_req & ~dm_done_q;
    assign streak_full = (streak_q == SW'(MAX_DM_STREAK));
    assign take_if     = ifv & (~dmv | streak_full);
    assign take_dm     = dmv & ~take_if;

    // Next-state and registered-output computation for the grant FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            IDLE: begin
                if (take_if) begin
                    state_d     = BUSY_IF;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                end else if (take_dm) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_d       = '0;
                    if (!ifv) begin
                        streak_d = '0;
                    end else if (!streak_full) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                // Ack has precedence over a timeout landing in the same cycle.
                if (mem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == BUSY_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_done    = if_done_q;
    assign dm_done    = dm_done_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign bus_err    = bus_err_q;
    assign pipe_stall = ifv | dmv;

    // Requesters must hold their request while their access is in flight.
    a_if_held: assert property (@(posedge clk) disable iff (rst) (state_q == BUSY_IF) |-> if_req);
    a_dm_held: assert property (@(posedge clk) disable iff (rst) (state_q == BUSY_DM) |-> dm_req);

endmodule
